// File: rtl/pic_debug_ctrl.sv
// -----------------------------------------------------------------------------
// pic_debug_ctrl
//
// Run / halt / single-step controller for the PIC16C55 core. Core progress is
// gated by a registered clock-enable (coreEn) that the fetch/execute sequencer,
// PC, IR, W and register-file writes honour. Halts only ever land on an
// instruction boundary, marked by the control unit's instDone pulse. The block
// also owns two PC breakpoints and a retired-instruction counter.
//
// Handshake: a debug command transfers on a rising clk edge where cmdValid and
// cmdReady are both 1. cmdReady depends only on internal state (never on
// cmdValid), the requester holds cmdOp/cmdIdx/cmdArg stable while cmdValid is
// high, and at most one command is taken per cycle.
//
// Ports
//   clk        in   core clock (single domain)
//   rst_n      in   asynchronous active-low reset
//   instDone   in   last-cycle-of-instruction pulse (ignored while coreEn=0)
//   pcIn       in   address of the next instruction during instDone
//   cmdValid   in   command request
//   cmdOp      in   0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SET_BP, 5 CLR_BP,
//                   6 CLR_CNT, 7 reserved (acts as NOP)
//   cmdIdx     in   breakpoint index for SET_BP / CLR_BP
//   cmdArg     in   breakpoint address for SET_BP
//   cmdReady   out  command can be accepted this cycle
//   coreEn     out  registered core advance enable
//   halted     out  controller is HALTED
//   bpHit      out  sticky: last halt came from a breakpoint
//   bpIndex    out  which breakpoint caused that halt
//   instCount  out  retired-instruction count (wraps)
//   dbg_state  out  raw FSM state for debug / checkers
// -----------------------------------------------------------------------------
module pic_debug_ctrl #(
  parameter int PC_WIDTH     = 9,
  parameter int CNT_WIDTH    = 16,
  parameter bit RUN_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instDone,
  input  logic [PC_WIDTH-1:0]  pcIn,
  input  logic                 cmdValid,
  input  logic [2:0]           cmdOp,
  input  logic                 cmdIdx,
  input  logic [PC_WIDTH-1:0]  cmdArg,
  output logic                 cmdReady,
  output logic                 coreEn,
  output logic                 halted,
  output logic                 bpHit,
  output logic                 bpIndex,
  output logic [CNT_WIDTH-1:0] instCount,
  output logic [1:0]           dbg_state
);

  // ---------------------------------------------------------------------------
  // Command opcodes
  // ---------------------------------------------------------------------------
  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_RUN     = 3'd1;
  localparam logic [2:0] OP_HALT    = 3'd2;
  localparam logic [2:0] OP_STEP    = 3'd3;
  localparam logic [2:0] OP_SET_BP  = 3'd4;
  localparam logic [2:0] OP_CLR_BP  = 3'd5;
  localparam logic [2:0] OP_CLR_CNT = 3'd6;

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_RUNNING  = 2'd0,
    ST_STOPPING = 2'd1,
    ST_STEPPING = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  localparam state_t RESET_STATE = RUN_ON_RESET ? ST_RUNNING : ST_HALTED;

  state_t state;
  state_t state_next;

  // ---------------------------------------------------------------------------
  // Command decode. Only accepted commands produce strobes; everything below
  // works on these strobes so "accepted but not applicable" naturally does
  // nothing.
  // ---------------------------------------------------------------------------
  logic cmd_acc;
  logic op_run;
  logic op_halt;
  logic op_step;
  logic op_set_bp;
  logic op_clr_bp;
  logic op_clr_cnt;

  assign cmd_acc = cmdValid && cmdReady;

  always_comb begin
    op_run     = 1'b0;
    op_halt    = 1'b0;
    op_step    = 1'b0;
    op_set_bp  = 1'b0;
    op_clr_bp  = 1'b0;
    op_clr_cnt = 1'b0;
    if (cmd_acc) begin
      case (cmdOp)
        OP_RUN:     op_run     = 1'b1;
        OP_HALT:    op_halt    = 1'b1;
        OP_STEP:    op_step    = 1'b1;
        OP_SET_BP:  op_set_bp  = 1'b1;
        OP_CLR_BP:  op_clr_bp  = 1'b1;
        OP_CLR_CNT: op_clr_cnt = 1'b1;
        OP_NOP:     ;
        default:    ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction retirement. instDone is only meaningful while the core is
  // enabled, so it is qualified with the registered coreEn.
  // ---------------------------------------------------------------------------
  logic done_live;

  assign done_live = instDone && coreEn;

  // ---------------------------------------------------------------------------
  // Breakpoints. The compare reads the registers as they stand this cycle, so
  // a SET_BP/CLR_BP accepted in the same cycle as a match only affects later
  // instructions.
  // ---------------------------------------------------------------------------
  logic [1:0][PC_WIDTH-1:0] bp_addr;
  logic [1:0]               bp_en;
  logic [1:0]               bp_match;
  logic                     bp_fire;

  always_comb begin
    bp_match = '0;
    for (int i = 0; i < 2; i++) begin
      bp_match[i] = bp_en[i] && (bp_addr[i] == pcIn);
    end
  end

  // Breakpoints are only armed while free-running; STEPPING and STOPPING
  // already end at the next boundary.
  assign bp_fire = done_live && (state == ST_RUNNING) && (|bp_match);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_addr <= '0;
      bp_en   <= '0;
    end else begin
      if (op_set_bp) begin
        bp_addr[cmdIdx] <= cmdArg;
        bp_en[cmdIdx]   <= 1'b1;
      end else if (op_clr_bp) begin
        bp_en[cmdIdx]   <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Run-control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_STATE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUNNING: begin
        // A breakpoint wins over a HALT in the same cycle; the HALT is
        // consumed because the core is stopped either way.
        if (bp_fire) begin
          state_next = ST_HALTED;
        end else if (op_halt) begin
          state_next = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if (done_live) begin
          state_next = ST_HALTED;
        end
      end
      ST_STEPPING: begin
        if (done_live) begin
          state_next = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (op_run) begin
          state_next = ST_RUNNING;
        end else if (op_step) begin
          state_next = ST_STEPPING;
        end
      end
      default: state_next = RESET_STATE;
    endcase
  end

  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Registered status outputs, loaded from the next state so that a halt on
  // the instDone edge drops coreEn on that same edge and the core never begins
  // the following instruction.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coreEn   <= RUN_ON_RESET;
      halted   <= !RUN_ON_RESET;
      cmdReady <= 1'b1;
    end else begin
      coreEn   <= (state_next != ST_HALTED);
      halted   <= (state_next == ST_HALTED);
      cmdReady <= (state_next == ST_RUNNING) || (state_next == ST_HALTED);
    end
  end

  // ---------------------------------------------------------------------------
  // Breakpoint status. bpHit is cleared when the core is restarted from
  // HALTED; bpIndex keeps its last value until the next breakpoint halt.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bpHit   <= 1'b0;
      bpIndex <= 1'b0;
    end else if (bp_fire) begin
      bpHit   <= 1'b1;
      // Index 0 has priority when both match.
      bpIndex <= !bp_match[0];
    end else if ((state == ST_HALTED) && (op_run || op_step)) begin
      bpHit   <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Retired-instruction counter, free-wrapping. A clear beats a same-cycle
  // increment.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instCount <= '0;
    end else if (op_clr_cnt) begin
      instCount <= '0;
    end else if (done_live) begin
      instCount <= instCount + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pic_debug_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for pic_debug_ctrl.
// Main instance: default parameters (runs from reset, 16-bit counter).
// Second instance: halted from reset, 4-bit counter to reach the wrap.
// -----------------------------------------------------------------------------
module tb_pic_debug_ctrl;

  localparam int PCW = 9;
  localparam int CW  = 16;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_RUN     = 3'd1;
  localparam logic [2:0] OP_HALT    = 3'd2;
  localparam logic [2:0] OP_STEP    = 3'd3;
  localparam logic [2:0] OP_SET_BP  = 3'd4;
  localparam logic [2:0] OP_CLR_BP  = 3'd5;
  localparam logic [2:0] OP_CLR_CNT = 3'd6;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Main DUT
  // ---------------------------------------------------------------------------
  logic           inst_done = 1'b0;
  logic [PCW-1:0] pc_in     = '0;
  logic           cmd_valid = 1'b0;
  logic [2:0]     cmd_op    = '0;
  logic           cmd_idx   = 1'b0;
  logic [PCW-1:0] cmd_arg   = '0;
  logic           cmd_ready;
  logic           core_en;
  logic           halted;
  logic           bp_hit;
  logic           bp_index;
  logic [CW-1:0]  inst_count;
  logic [1:0]     dbg_state;

  pic_debug_ctrl #(
    .PC_WIDTH     (PCW),
    .CNT_WIDTH    (CW),
    .RUN_ON_RESET (1'b1)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instDone  (inst_done),
    .pcIn      (pc_in),
    .cmdValid  (cmd_valid),
    .cmdOp     (cmd_op),
    .cmdIdx    (cmd_idx),
    .cmdArg    (cmd_arg),
    .cmdReady  (cmd_ready),
    .coreEn    (core_en),
    .halted    (halted),
    .bpHit     (bp_hit),
    .bpIndex   (bp_index),
    .instCount (inst_count),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Second DUT: halted from reset, narrow counter
  // ---------------------------------------------------------------------------
  logic           h_inst_done = 1'b0;
  logic           h_cmd_valid = 1'b0;
  logic [2:0]     h_cmd_op    = '0;
  logic           h_cmd_ready;
  logic           h_core_en;
  logic           h_halted;
  logic           h_bp_hit;
  logic           h_bp_index;
  logic [3:0]     h_inst_count;
  logic [1:0]     h_dbg_state;

  pic_debug_ctrl #(
    .PC_WIDTH     (PCW),
    .CNT_WIDTH    (4),
    .RUN_ON_RESET (1'b0)
  ) u_dut_h (
    .clk       (clk),
    .rst_n     (rst_n),
    .instDone  (h_inst_done),
    .pcIn      (9'h000),
    .cmdValid  (h_cmd_valid),
    .cmdOp     (h_cmd_op),
    .cmdIdx    (1'b0),
    .cmdArg    (9'h000),
    .cmdReady  (h_cmd_ready),
    .coreEn    (h_core_en),
    .halted    (h_halted),
    .bpHit     (h_bp_hit),
    .bpIndex   (h_bp_index),
    .instCount (h_inst_count),
    .dbg_state (h_dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model (main DUT)
  // Mode is tracked by name; expected counts go through exp_q.
  // ---------------------------------------------------------------------------
  int unsigned    n_vec = 0;
  int unsigned    n_err = 0;

  string          m_mode;
  logic [PCW-1:0] m_bp_addr [2];
  bit             m_bp_en   [2];
  bit             m_hit;
  bit             m_idx;
  int unsigned    m_cnt;
  logic [CW-1:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode       = "RUN";
    m_bp_addr[0] = '0;
    m_bp_addr[1] = '0;
    m_bp_en[0]   = 1'b0;
    m_bp_en[1]   = 1'b0;
    m_hit        = 1'b0;
    m_idx        = 1'b0;
    m_cnt        = 0;
    exp_q.delete();
  endtask

  // Apply the rules for one clock edge given the inputs present at that edge.
  task automatic model_step(input bit v, input logic [2:0] op, input bit idx,
                            input logic [PCW-1:0] arg, input bit done,
                            input logic [PCW-1:0] pc);
    bit    ready;
    bit    acc;
    bit    d;
    bit    hit0;
    bit    hit1;
    string nm;
    ready = (m_mode == "RUN") || (m_mode == "HALT");
    acc   = v && ready;
    d     = done && (m_mode != "HALT");
    hit0  = d && m_bp_en[0] && (m_bp_addr[0] == pc);
    hit1  = d && m_bp_en[1] && (m_bp_addr[1] == pc);
    nm    = m_mode;
    if (m_mode == "RUN") begin
      if (hit0 || hit1) begin
        nm    = "HALT";
        m_hit = 1'b1;
        m_idx = hit0 ? 1'b0 : 1'b1;
      end else if (acc && op == OP_HALT) begin
        nm = "STOP";
      end
    end else if (m_mode == "STOP" || m_mode == "STEP") begin
      if (d) nm = "HALT";
    end else begin
      if (acc && (op == OP_RUN || op == OP_STEP)) begin
        nm    = (op == OP_RUN) ? "RUN" : "STEP";
        m_hit = 1'b0;
      end
    end
    if (acc && op == OP_SET_BP) begin
      m_bp_addr[idx] = arg;
      m_bp_en[idx]   = 1'b1;
    end else if (acc && op == OP_CLR_BP) begin
      m_bp_en[idx] = 1'b0;
    end
    if (acc && op == OP_CLR_CNT) m_cnt = 0;
    else if (d) m_cnt = (m_cnt + 1) % (1 << CW);
    m_mode = nm;
    exp_q.push_back(CW'(m_cnt));
  endtask

  task automatic compare_all();
    logic [CW-1:0] exp_cnt;
    exp_cnt = exp_q.pop_front();
    check("core_en",   core_en,    (m_mode != "HALT"));
    check("halted",    halted,     (m_mode == "HALT"));
    check("cmd_ready", cmd_ready,  (m_mode == "RUN") || (m_mode == "HALT"));
    check("bp_hit",    bp_hit,     m_hit);
    check("bp_index",  bp_index,   m_idx);
    check("inst_count", inst_count, exp_cnt);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (main DUT)
  // ---------------------------------------------------------------------------
  task automatic do_cycle(input bit v, input logic [2:0] op, input bit idx,
                          input logic [PCW-1:0] arg, input bit done,
                          input logic [PCW-1:0] pc);
    cmd_valid = v;
    cmd_op    = op;
    cmd_idx   = idx;
    cmd_arg   = arg;
    inst_done = done;
    pc_in     = pc;
    @(posedge clk);
    #1;
    model_step(v, op, idx, arg, done, pc);
    cmd_valid = 1'b0;
    inst_done = 1'b0;
    compare_all();
  endtask

  task automatic cmd(input logic [2:0] op, input bit idx, input logic [PCW-1:0] arg);
    do_cycle(1'b1, op, idx, arg, 1'b0, '0);
  endtask

  task automatic retire(input logic [PCW-1:0] pc);
    do_cycle(1'b0, OP_NOP, 1'b0, '0, 1'b1, pc);
  endtask

  task automatic idle();
    do_cycle(1'b0, OP_NOP, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic h_cycle(input bit v, input logic [2:0] op, input bit done);
    h_cmd_valid = v;
    h_cmd_op    = op;
    h_inst_done = done;
    @(posedge clk);
    #1;
    h_cmd_valid = 1'b0;
    h_inst_done = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence, then randomized traffic
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    #12;
    check("rst_core_en",   core_en,    1'b1);
    check("rst_halted",    halted,     1'b0);
    check("rst_count",     inst_count, '0);
    check("rst_ready",     cmd_ready,  1'b1);
    check("rst_bp_hit",    bp_hit,     1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Counting while running
    for (int i = 0; i < 3; i++) retire(9'h001);
    check("cnt3", inst_count, 16'd3);

    // Breakpoint 0 halts on the matching boundary only
    cmd(OP_CLR_CNT, 1'b0, '0);
    cmd(OP_SET_BP, 1'b0, 9'h005);
    retire(9'h004);
    check("bp_nomatch_halted", halted, 1'b0);
    retire(9'h005);
    check("bp0_core_en", core_en,    1'b0);
    check("bp0_halted",  halted,     1'b1);
    check("bp0_hit",     bp_hit,     1'b1);
    check("bp0_index",   bp_index,   1'b0);
    check("bp0_count",   inst_count, 16'd2);

    // HALT waits for the instruction boundary
    cmd(OP_RUN, 1'b0, '0);
    cmd(OP_HALT, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      idle();
      check("stop_core_en", core_en,   1'b1);
      check("stop_ready",   cmd_ready, 1'b0);
    end
    retire(9'h020);
    check("stop_halted", halted, 1'b1);
    check("stop_bp_hit", bp_hit, 1'b0);

    // STEP ignores an enabled breakpoint and retires one instruction
    cmd(OP_STEP, 1'b0, '0);
    retire(9'h005);
    check("step_halted", halted,     1'b1);
    check("step_bp_hit", bp_hit,     1'b0);
    check("step_count",  inst_count, 16'd4);

    // Both breakpoints match together with a HALT command
    cmd(OP_SET_BP, 1'b0, 9'h010);
    cmd(OP_SET_BP, 1'b1, 9'h010);
    cmd(OP_RUN, 1'b0, '0);
    do_cycle(1'b1, OP_HALT, 1'b0, '0, 1'b1, 9'h010);
    check("dual_halted", halted,   1'b1);
    check("dual_hit",    bp_hit,   1'b1);
    check("dual_index",  bp_index, 1'b0);

    // CLR_CNT beats a simultaneous increment
    cmd(OP_RUN, 1'b0, '0);
    do_cycle(1'b1, OP_CLR_CNT, 1'b0, '0, 1'b1, 9'h001);
    check("clr_cnt_prio", inst_count, 16'd0);

    // Only breakpoint 1 left armed
    cmd(OP_CLR_BP, 1'b0, '0);
    retire(9'h010);
    check("bp1_halted", halted,   1'b1);
    check("bp1_index",  bp_index, 1'b1);

    // Reset in the middle of a step
    cmd(OP_STEP, 1'b0, '0);
    rst_n = 1'b0;
    #2;
    check("mid_rst_core_en", core_en,    1'b1);
    check("mid_rst_halted",  halted,     1'b0);
    check("mid_rst_ready",   cmd_ready,  1'b1);
    check("mid_rst_count",   inst_count, '0);
    check("mid_rst_bp_hit",  bp_hit,     1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    retire(9'h010);
    check("post_rst_no_halt", halted, 1'b0);

    // Same-cycle SET_BP does not affect the current match
    do_cycle(1'b1, OP_SET_BP, 1'b0, 9'h040, 1'b1, 9'h040);
    check("set_same_cycle", halted, 1'b0);
    retire(9'h040);
    check("set_next_cycle", halted, 1'b1);

    // Same-cycle CLR_BP does not suppress the current match
    cmd(OP_RUN, 1'b0, '0);
    do_cycle(1'b1, OP_CLR_BP, 1'b0, '0, 1'b1, 9'h040);
    check("clr_same_cycle", halted, 1'b1);

    // Randomized traffic against the model
    cmd(OP_RUN, 1'b0, '0);
    for (int i = 0; i < 600; i++) begin
      bit             v;
      logic [2:0]     op;
      bit             idx;
      logic [PCW-1:0] arg;
      bit             done;
      logic [PCW-1:0] pc;
      v    = ($urandom_range(0, 2) != 0);
      op   = 3'($urandom_range(0, 7));
      idx  = 1'($urandom_range(0, 1));
      arg  = PCW'($urandom_range(0, 15));
      done = (m_mode != "HALT") && ($urandom_range(0, 2) == 0);
      pc   = PCW'($urandom_range(0, 15));
      do_cycle(v, op, idx, arg, done, pc);
    end

    // Second instance: halted from reset, narrow counter wraps
    check("h_rst_halted",  h_halted,     1'b1);
    check("h_rst_core_en", h_core_en,    1'b0);
    check("h_rst_ready",   h_cmd_ready,  1'b1);
    check("h_rst_count",   h_inst_count, 4'd0);
    h_cycle(1'b1, OP_HALT, 1'b0);
    check("h_halt_in_halted", h_halted,    1'b1);
    check("h_halt_ready",     h_cmd_ready, 1'b1);
    h_cycle(1'b1, OP_RUN, 1'b0);
    check("h_run_core_en", h_core_en, 1'b1);
    for (int i = 0; i < 15; i++) h_cycle(1'b0, OP_NOP, 1'b1);
    check("h_count15", h_inst_count, 4'd15);
    h_cycle(1'b0, OP_NOP, 1'b1);
    check("h_count_wrap", h_inst_count, 4'd0);
    h_cycle(1'b0, OP_NOP, 1'b1);
    check("h_count_after_wrap", h_inst_count, 4'd1);
    h_cycle(1'b1, OP_HALT, 1'b0);
    check("h_stopping_ready", h_cmd_ready, 1'b0);
    h_cycle(1'b0, OP_NOP, 1'b1);
    check("h_stop_halted", h_halted,     1'b1);
    check("h_stop_count",  h_inst_count, 4'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pic_debug_ctrl.md
# pic_debug_ctrl

Run/halt/single-step controller for the PIC16C55 core. It gates core progress through a clock-enable (`coreEn`) that the fetch/execute sequencer, PC, IR, W and register-file writes honour. It accepts debug commands over a valid/ready handshake and halts the core on two PC breakpoints. Halts take effect only on instruction boundaries, signalled by the control unit's end-of-instruction pulse. It also maintains a retired-instruction counter.

## Interface
Parameters:
- `PC_WIDTH`, 9, program counter width (512-word program memory)
- `CNT_WIDTH`, 16, retired-instruction counter width
- `RUN_ON_RESET`, 1, 1 = RUNNING after reset, 0 = HALTED after reset

Ports:
- `clk`  in  1  core clock, single clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `instDone`  in  1  one-cycle pulse in the last cycle of an instruction; meaningful only while `coreEn`=1
- `pcIn`  in  PC_WIDTH  core PC; in the `instDone` cycle it holds the address of the next instruction
- `cmdValid`  in  1  command request
- `cmdOp`  in  3  0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 CLR_CNT, 7 reserved (treated as NOP)
- `cmdIdx`  in  1  breakpoint index for SET_BP/CLR_BP
- `cmdArg`  in  PC_WIDTH  breakpoint address for SET_BP
- `cmdReady`  out  1  a command is accepted when `cmdValid` and `cmdReady` are both 1 on a rising edge
- `coreEn`  out  1  registered core advance enable
- `halted`  out  1  state == HALTED
- `bpHit`  out  1  sticky: the last halt was caused by a breakpoint
- `bpIndex`  out  1  index of the breakpoint that hit
- `instCount`  out  CNT_WIDTH  retired-instruction count

## Operation
States:
- RUNNING: `coreEn`=1.
- STOPPING: `coreEn`=1; waiting for `instDone` to finish the current instruction.
- STEPPING: `coreEn`=1; executing exactly one instruction.
- HALTED: `coreEn`=0.

Transitions:
- HALTED + RUN → RUNNING.
- HALTED + STEP → STEPPING.
- RUNNING + HALT → STOPPING.
- STOPPING + `instDone` → HALTED.
- STEPPING + `instDone` → HALTED.
- RUNNING + `instDone` with a breakpoint match → HALTED; set `bpHit`=1 and `bpIndex`.

Breakpoints:
- Two breakpoints, each with an address register and an enable bit.
- A match means the breakpoint is enabled and its address equals `pcIn` in an `instDone` cycle.
- Matches are evaluated only in RUNNING. STEPPING and STOPPING ignore breakpoints.
- If both breakpoints match, `bpIndex` reports index 0.
- SET_BP writes the address register[`cmdIdx`] from `cmdArg` and sets its enable. CLR_BP clears enable[`cmdIdx`]. Both are legal in any state where `cmdReady`=1 and take effect from the next cycle.

Other commands:
- RUN or STEP accepted in HALTED clears `bpHit`.
- Commands that do not apply in the current state are accepted and have no effect: RUN/STEP in RUNNING, HALT in HALTED, NOP, reserved.
- CLR_CNT zeroes `instCount` in the next cycle. It has priority over a simultaneous increment.

Command ready:
- `cmdReady`=1 in RUNNING and HALTED.
- `cmdReady`=0 in STOPPING and STEPPING.

Counter:
- `instCount` increments by 1 on every `instDone` while `coreEn`=1.
- It wraps modulo 2^CNT_WIDTH with no saturation and no flag.

Simultaneous events:
- Breakpoint match and an accepted HALT in the same RUNNING cycle: go to HALTED with `bpHit`=1; the HALT is consumed.
- Breakpoint match and an accepted SET_BP/CLR_BP in the same cycle: the match uses the breakpoint values from before the write.

Reset (also applies mid-operation):
- State = RUNNING if `RUN_ON_RESET`, otherwise HALTED. `coreEn` = `RUN_ON_RESET`.
- `bpHit`=0, `bpIndex`=0, `instCount`=0.
- Both breakpoint enables = 0; breakpoint addresses = 0.
- `cmdReady`=1.
- An instruction in flight is abandoned; no partial state is kept.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Command acceptance at edge N: the new state and `coreEn` are visible after edge N.
- RUN/STEP from HALTED: `coreEn` rises one cycle after acceptance.
- Halt latency:
  - `instDone` at edge M in STOPPING, STEPPING, or RUNNING with a breakpoint match: `coreEn`=0 and `halted`=1 from edge M.
  - The core therefore never starts the next instruction's first cycle.
- A STEP retires exactly one instruction, including 2-cycle instructions (GOTO, CALL, taken skips). `instDone` is asserted only at the true end of the instruction.
- Back-to-back commands: one per cycle while `cmdReady`=1.

## Test plan
- Reset with RUN_ON_RESET=1: `coreEn`=1, `halted`=0, `instCount`=0, `cmdReady`=1. Pulse `instDone` 3 times → `instCount`=3.
- SET_BP idx0 `cmdArg`=0x005, run, then `instDone` with `pcIn`=0x004 (no halt) and `pcIn`=0x005 → `coreEn`=0 the next cycle, `halted`=1, `bpHit`=1, `bpIndex`=0, `instCount`=2.
- HALT accepted with no `instDone` for 4 cycles → `coreEn` stays 1, `cmdReady`=0. Then `instDone` → `halted`=1, `bpHit`=0.
- From HALTED, STEP with `pcIn`=0x005 on `instDone` while bp0=0x005 is enabled → one instruction retires, HALTED, `bpHit`=0, `instCount` +1.
- Both breakpoints = 0x010 with simultaneous HALT command on a matching `instDone` → `bpIndex`=0, `bpHit`=1, HALTED. Then CLR_CNT with a concurrent increment → `instCount`=0.
- Assert `rst_n` low mid-STEPPING with bp1 enabled → immediately `coreEn`=RUN_ON_RESET and breakpoints disabled. After release, an `instDone` with `pcIn` equal to the old bp1 address → no halt.
